nco_tdm_multi: RTL and testbench

//  Time-multiplexed, multi-channel numerically controlled oscillator. One shared

---
 rtl/nco_tdm_multi.sv | 221 ++++++++++++++++++++++
 tb/tb_nco_tdm_multi.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_tdm_multi.sv
// Time-multiplexed multi-channel NCO.
// One shared phase-add -> quarter-wave LUT -> sign pipeline serves NUM_CH
// channels round-robin, one channel per clken cycle. Each channel's phase
// increment, frequency-mod and phase-mod words are double-buffered. Shadow
// values reach the active set only at a frame boundary, so a frame never
// mixes old and new configuration. Accumulator zeroing (sync) is also
// aligned to the frame boundary.
module nco_tdm_multi #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 32,
  parameter int PMOD_W = 16,
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 18
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clken,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [1:0]                cfg_sel,
  input  logic [ACC_W-1:0]          cfg_data,
  input  logic                      cfg_commit,
  input  logic                      sync_i,
  output logic                      out_valid,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_sof,
  output logic [OUT_W-1:0]          sin_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int LUT_N = 2 ** LUT_AW;
  localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    SEL_PHI  = 2'd0,
    SEL_FMOD = 2'd1,
    SEL_PMOD = 2'd2,
    SEL_NONE = 2'd3
  } cfg_sel_e;

  // ---------------------------------------------------------------------
  // Quarter-wave sine table. Samples sit half a step off the axis, so no
  // entry is zero, both halves of the wave are mirror images and the
  // largest entry (2^(OUT_W-1)-1) can always be negated.
  // ---------------------------------------------------------------------
  function automatic logic [OUT_W-1:0] lut_entry(input int k);
    real amp;
    real ang;
    amp = real'((2 ** (OUT_W - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(4 * LUT_N);
    return OUT_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  logic [OUT_W-1:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic [OUT_W-1:0] ENTRY = lut_entry(k);
    assign lut[k] = ENTRY;
  end

  // ---------------------------------------------------------------------
  // Configuration and per-channel state
  // ---------------------------------------------------------------------
  logic [ACC_W-1:0]  phi_sh   [NUM_CH];
  logic [ACC_W-1:0]  fmod_sh  [NUM_CH];
  logic [PMOD_W-1:0] pmod_sh  [NUM_CH];
  logic [ACC_W-1:0]  phi_act  [NUM_CH];
  logic [ACC_W-1:0]  fmod_act [NUM_CH];
  logic [PMOD_W-1:0] pmod_act [NUM_CH];
  logic [ACC_W-1:0]  acc      [NUM_CH];

  logic [ACC_W-1:0]  phi_nx   [NUM_CH];
  logic [ACC_W-1:0]  fmod_nx  [NUM_CH];
  logic [PMOD_W-1:0] pmod_nx  [NUM_CH];

  logic [CH_W-1:0] slot;
  logic            commit_pend;
  logic            sync_pend;
  logic            ch_ok;
  logic            frame_end;
  logic            do_commit;
  logic            do_sync;

  // Out-of-range channel numbers only exist when NUM_CH is not a power of two.
  if ((1 << CH_W) == NUM_CH) begin : g_ch_pow2
    assign ch_ok = 1'b1;
  end else begin : g_ch_range
    assign ch_ok = (32'(cfg_ch) < 32'(NUM_CH));
  end

  assign frame_end = (slot == LAST_SLOT);
  assign do_commit = frame_end && (commit_pend || cfg_commit);
  assign do_sync   = frame_end && (sync_pend || sync_i);

  // Shadow set including this cycle's write, so a write in the commit cycle
  // is part of the copy.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // values produced by earlier ones; clocked blocks use '<=' exclusively.
    // NOTE: every output starts from a default so no path leaves one
    // unassigned, which is what would otherwise infer a latch.
    phi_nx  = phi_sh;
    fmod_nx = fmod_sh;
    pmod_nx = pmod_sh;
    if (cfg_we && ch_ok) begin
      case (cfg_sel_e'(cfg_sel))
        SEL_PHI:  phi_nx[cfg_ch]  = cfg_data;
        SEL_FMOD: fmod_nx[cfg_ch] = cfg_data;
        SEL_PMOD: pmod_nx[cfg_ch] = cfg_data[PMOD_W-1:0];
        default:  ;
      endcase
    end
  end

  // Shadow/active registers, pending flags, slot counter and accumulators.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phi_sh      <= '{default: '0};
      fmod_sh     <= '{default: '0};
      pmod_sh     <= '{default: '0};
      phi_act     <= '{default: '0};
      fmod_act    <= '{default: '0};
      pmod_act    <= '{default: '0};
      acc         <= '{default: '0};
      slot        <= '0;
      commit_pend <= 1'b0;
      sync_pend   <= 1'b0;
    end else if (clken) begin
      phi_sh  <= phi_nx;
      fmod_sh <= fmod_nx;
      pmod_sh <= pmod_nx;
      if (do_commit) begin
        phi_act  <= phi_nx;
        fmod_act <= fmod_nx;
        pmod_act <= pmod_nx;
      end
      commit_pend <= frame_end ? 1'b0 : (commit_pend || cfg_commit);
      sync_pend   <= frame_end ? 1'b0 : (sync_pend || sync_i);
      slot        <= frame_end ? '0 : slot + CH_W'(1);
      if (do_sync) begin
        for (int c = 0; c < NUM_CH; c++) begin
          acc[c] <= '0;
        end
      end else begin
        acc[slot] <= acc[slot] + phi_act[slot] + fmod_act[slot];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sample pipeline: phase -> LUT read -> sign
  // ---------------------------------------------------------------------
  logic [PMOD_W-1:0] phase_s1;
  logic [PMOD_W-1:0] phase_q1;
  logic [CH_W-1:0]   ch_q1;
  logic              valid_q1;

  logic [1:0]        quad;
  logic [LUT_AW-1:0] lut_i;
  logic [LUT_AW-1:0] lut_idx;
  logic [OUT_W-1:0]  lut_q2;
  logic              neg_q2;
  logic [CH_W-1:0]   ch_q2;
  logic              valid_q2;

  logic              valid_q3;

  // Truncated phase uses the accumulator value before this cycle's update.
  assign phase_s1 = acc[slot][ACC_W-1 -: PMOD_W] + pmod_act[slot];

  assign quad    = phase_q1[PMOD_W-1 -: 2];
  assign lut_i   = phase_q1[PMOD_W-3 -: LUT_AW];
  assign lut_idx = quad[0] ? ~lut_i : lut_i;

  // Phase bits below the LUT address are deliberately dropped.
  if (PMOD_W > LUT_AW + 2) begin : g_phase_lsbs
    logic unused_phase_lsbs;
    assign unused_phase_lsbs = ^phase_q1[PMOD_W-LUT_AW-3:0];
  end

  // Pipeline control, phase and sign stages; everything freezes with clken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q1 <= 1'b0;
      phase_q1 <= '0;
      ch_q1    <= '0;
      valid_q2 <= 1'b0;
      neg_q2   <= 1'b0;
      ch_q2    <= '0;
      valid_q3 <= 1'b0;
      sin_o    <= '0;
      out_ch   <= '0;
      out_sof  <= 1'b0;
    end else if (clken) begin
      valid_q1 <= 1'b1;
      phase_q1 <= phase_s1;
      ch_q1    <= slot;
      valid_q2 <= valid_q1;
      neg_q2   <= quad[1];
      ch_q2    <= ch_q1;
      valid_q3 <= valid_q2;
      if (valid_q2) begin
        sin_o   <= neg_q2 ? -lut_q2 : lut_q2;
        out_ch  <= ch_q2;
        out_sof <= (ch_q2 == '0);
      end
    end
  end

  // Registered table read, kept free of reset so it maps onto a ROM.
  always_ff @(posedge clk) begin
    // NOTE: the table read register has no reset; valid_q2 qualifies its
    // contents, so a stale value after reset is never used.
    if (clken) begin
      lut_q2 <= lut[lut_idx];
    end
  end

  assign out_valid = valid_q3 && clken;

endmodule

// File: tb/tb_nco_tdm_multi.sv
// Self-checking bench for nco_tdm_multi: a behavioural model computes each
// channel's sample from full-wave sine arithmetic and frame-level config
// rules; directed scenarios plus randomized traffic are compared against it.
module tb_nco_tdm_multi;

  localparam int NUM_CH = 4;
  localparam int ACC_W  = 32;
  localparam int PMOD_W = 16;
  localparam int LUT_AW = 10;
  localparam int OUT_W  = 18;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int LAT    = 3;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = real'((2 ** (OUT_W - 1)) - 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clken = 1'b1;
  logic              cfg_we = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [1:0]        cfg_sel = '0;
  logic [ACC_W-1:0]  cfg_data = '0;
  logic              cfg_commit = 1'b0;
  logic              sync_i = 1'b0;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic              out_sof;
  logic [OUT_W-1:0]  sin_o;

  always #5 clk = ~clk;

  nco_tdm_multi #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .PMOD_W(PMOD_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .sync_i(sync_i),
    .out_valid(out_valid), .out_ch(out_ch), .out_sof(out_sof), .sin_o(sin_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ------------------------------ model --------------------------------
  typedef struct {
    int ch;
    int val;
  } samp_t;

  bit [ACC_W-1:0]  m_phi_sh [NUM_CH];
  bit [ACC_W-1:0]  m_fmod_sh[NUM_CH];
  bit [PMOD_W-1:0] m_pmod_sh[NUM_CH];
  bit [ACC_W-1:0]  m_phi    [NUM_CH];
  bit [ACC_W-1:0]  m_fmod   [NUM_CH];
  bit [PMOD_W-1:0] m_pmod   [NUM_CH];
  bit [ACC_W-1:0]  m_acc    [NUM_CH];
  int              m_slot;
  bit              m_cpend;
  bit              m_spend;
  samp_t           exp_q[$];
  int              obs[NUM_CH];
  int              ch0_hist[$];

  // Sine sampled at the centre of the addressed step, rounded half away from zero.
  function automatic int ref_sample(input bit [ACC_W-1:0] acc, input bit [PMOD_W-1:0] pmod);
    bit [PMOD_W-1:0] ph;
    int  m;
    real s;
    real r;
    ph = acc[ACC_W-1 -: PMOD_W] + pmod;
    m  = int'(ph >> (PMOD_W - LUT_AW - 2));
    s  = $sin(2.0 * PI * (real'(m) + 0.5) / real'(2 ** (LUT_AW + 2)));
    r  = $floor(AMP * ((s < 0.0) ? -s : s) + 0.5);
    return (s < 0.0) ? -int'(r) : int'(r);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_phi_sh[c] = '0; m_fmod_sh[c] = '0; m_pmod_sh[c] = '0;
      m_phi[c] = '0; m_fmod[c] = '0; m_pmod[c] = '0; m_acc[c] = '0;
    end
    m_slot = 0;
    m_cpend = 1'b0;
    m_spend = 1'b0;
    exp_q.delete();
  endtask

  // One clock: advance the model with the current inputs, clock, then compare.
  task automatic tick();
    samp_t e;
    bit    have;
    int    s;
    int    got;
    have = 1'b0;
    e.ch = 0;
    e.val = 0;
    if (!reset_n) begin
      model_reset();
    end else if (clken) begin
      if (cfg_we && int'(cfg_ch) < NUM_CH) begin
        case (cfg_sel)
          2'd0: m_phi_sh[cfg_ch]  = cfg_data;
          2'd1: m_fmod_sh[cfg_ch] = cfg_data;
          2'd2: m_pmod_sh[cfg_ch] = cfg_data[PMOD_W-1:0];
          default: ;
        endcase
      end
      if (cfg_commit) m_cpend = 1'b1;
      if (sync_i) m_spend = 1'b1;
      s = m_slot;
      e.ch = s;
      e.val = ref_sample(m_acc[s], m_pmod[s]);
      exp_q.push_back(e);
      m_acc[s] = m_acc[s] + m_phi[s] + m_fmod[s];
      m_slot++;
      if (m_slot == NUM_CH) begin
        m_slot = 0;
        if (m_cpend) begin
          m_phi = m_phi_sh; m_fmod = m_fmod_sh; m_pmod = m_pmod_sh;
          m_cpend = 1'b0;
        end
        if (m_spend) begin
          for (int c = 0; c < NUM_CH; c++) m_acc[c] = '0;
          m_spend = 1'b0;
        end
      end
      if (exp_q.size() == LAT) begin
        e = exp_q.pop_front();
        have = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (!reset_n) begin
      check("rst_valid", out_valid, 0);
      check("rst_ch", out_ch, 0);
      check("rst_sof", out_sof, 0);
      check("rst_sin", sin_o, 0);
    end else if (!clken) begin
      check("hold_valid", out_valid, 0);
    end else begin
      check("valid", out_valid, have);
      if (have) begin
        got = int'(signed'(sin_o));
        check("out_ch", out_ch, e.ch);
        check("out_sof", out_sof, (e.ch == 0));
        check($sformatf("sin_ch%0d", e.ch), got, e.val);
        obs[e.ch] = got;
        if (e.ch == 0) ch0_hist.push_back(got);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg_write(input int ch, input int sel, input logic [ACC_W-1:0] data);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_sel = 2'(sel); cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_slot(input int s);
    int guard;
    guard = 0;
    while (m_slot != s && guard < 2 * NUM_CH) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int last_ch;
    int n;
    model_reset();

    // Reset state
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;

    // Quadrature pmod on four channels
    cfg_write(0, 2, 32'h0000);
    cfg_write(1, 2, 32'h4000);
    cfg_write(2, 2, 32'h8000);
    cfg_write(3, 2, 32'hC000);
    commit();
    idle(3 * NUM_CH);
    check("t1_ch0", obs[0], 101);
    check("t1_ch1", obs[1], 131071);
    check("t1_ch2", obs[2], -101);
    check("t1_ch3", obs[3], -131071);

    // Shadow write without commit, then commit in slot 1
    cfg_write(1, 2, 32'h0000);
    idle(5 * NUM_CH);
    check("t4_no_commit", obs[1], 131071);
    wait_slot(1);
    commit();
    idle(2);
    check("t4_same_frame", obs[1], 131071);
    idle(NUM_CH);
    check("t4_next_frame", obs[1], 101);

    // Quarter-turn increment on ch0, committed at the frame boundary
    cfg_write(0, 0, 32'h4000_0000);
    wait_slot(NUM_CH - 1);
    commit();
    ch0_hist.delete();
    idle(5 * NUM_CH);
    check("t2_count", ch0_hist.size(), 5);
    if (ch0_hist.size() >= 5) begin
      check("t2_f0", ch0_hist[0], 101);
      check("t2_f1", ch0_hist[1], 131071);
      check("t2_f2", ch0_hist[2], -101);
      check("t2_f3", ch0_hist[3], -131071);
      check("t2_wrap", ch0_hist[4], 101);
    end

    // Sync requested mid-frame
    idle(3 * NUM_CH);
    wait_slot(2);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    ch0_hist.delete();
    idle(2 * NUM_CH);
    check("t3_count", ch0_hist.size(), 2);
    if (ch0_hist.size() >= 2) begin
      check("t3_sync_ch0", ch0_hist[0], 101);
      check("t3_after", ch0_hist[1], 131071);
    end

    // clken gap mid-frame
    idle(NUM_CH + 1);
    last_ch = int'(out_ch);
    clken = 1'b0;
    idle(7);
    clken = 1'b1;
    tick();
    check("t5_resume_ch", out_ch, (last_ch + 1) % NUM_CH);
    idle(2 * NUM_CH);

    // Reset mid-frame with non-zero config
    cfg_write(2, 1, 32'h0123_4567);
    cfg_write(3, 0, 32'h0765_4321);
    commit();
    idle(2 * NUM_CH);
    wait_slot(2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 8);
    check("t6_first_valid", n, LAT);
    check("t6_first_ch", out_ch, 0);
    check("t6_active_zero", int'(signed'(sin_o)), 101);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset_n    = ($urandom_range(0, 299) != 0);
      clken      = ($urandom_range(0, 9) != 0);
      cfg_we     = ($urandom_range(0, 9) < 3);
      cfg_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_sel    = 2'($urandom_range(0, 3));
      cfg_data   = $urandom();
      cfg_commit = ($urandom_range(0, 9) == 0);
      sync_i     = ($urandom_range(0, 19) == 0);
      tick();
    end
    reset_n = 1'b1; clken = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; sync_i = 1'b0;
    idle(2 * NUM_CH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
